// File: rtl/cpu_types_pkg.sv
// Shared CPU types: the instruction word and the direct-mapped frame layout
// for the default 16-set instruction cache.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam int ICACHE_SETS  = 16;
  localparam int ICACHE_IDX_W = $clog2(ICACHE_SETS);
  localparam int ICACHE_TAG_W = 30 - ICACHE_IDX_W;

  typedef struct packed {
    logic                    valid;
    logic [ICACHE_TAG_W-1:0] tag;
    word_t                   data;
  } frame_t;

endpackage

// File: rtl/icache_if.sv
// Datapath-side and memory-side signals of the instruction cache, bundled so
// the cache and its environment can be connected as one port.
interface icache_if;

  logic                 imemREN;
  cpu_types_pkg::word_t imemaddr;
  logic                 halt;
  logic                 ihit;
  cpu_types_pkg::word_t imemload;
  logic                 iREN;
  cpu_types_pkg::word_t iaddr;
  logic                 iwait;
  cpu_types_pkg::word_t iload;
  cpu_types_pkg::word_t hit_count;
  cpu_types_pkg::word_t miss_count;

  modport slave (
    input  imemREN, imemaddr, halt, iwait, iload,
    output ihit, imemload, iREN, iaddr, hit_count, miss_count
  );

  modport master (
    output imemREN, imemaddr, halt, iwait, iload,
    input  ihit, imemload, iREN, iaddr, hit_count, miss_count
  );

endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-frame instruction cache. Hits are answered in
// the same cycle; a miss fetches one word from memory and then replays as a hit.
module icache
  import cpu_types_pkg::*;
#(
  parameter int SETS = 16
) (
  input  logic      CLK,
  input  logic      nRST,
  icache_if.slave   bus
);

  localparam int IDX_BITS = $clog2(SETS);
  localparam int TAG_BITS = 30 - IDX_BITS;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t              state, next_state;
  logic [SETS-1:0]     valid;
  logic [TAG_BITS-1:0] tags [SETS];
  word_t               data [SETS];
  logic [29:0]         miss_word;
  word_t               hit_cnt, miss_cnt;

  logic [IDX_BITS-1:0] idx;
  logic [TAG_BITS-1:0] tag;
  logic                lookup_hit, start_fill, fill_done;
  logic                unused_addr_bits;

  assign idx              = bus.imemaddr[IDX_BITS+1:2];
  assign tag              = bus.imemaddr[31:IDX_BITS+2];
  assign unused_addr_bits = ^bus.imemaddr[1:0];

  assign lookup_hit = valid[idx] && (tags[idx] == tag);
  assign start_fill = (state == IDLE) && bus.imemREN && !lookup_hit && !bus.halt;
  assign fill_done  = (state == FETCH) && !bus.iwait;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start_fill) next_state = FETCH;
      FETCH:   if (!bus.iwait) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.ihit     = 1'b0;
    bus.imemload = '0;
    bus.iREN     = 1'b0;
    bus.iaddr    = '0;
    case (state)
      IDLE: begin
        bus.ihit     = bus.imemREN && lookup_hit;
        bus.imemload = bus.ihit ? data[idx] : '0;
      end
      FETCH: begin
        bus.iREN  = 1'b1;
        bus.iaddr = {miss_word, 2'b00};
      end
      default: ;
    endcase
  end

  // Valid bits and the miss address are reset; a reset mid-fetch therefore
  // simply drops the pending fill.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid     <= '0;
      miss_word <= '0;
    end else begin
      if (start_fill) miss_word <= bus.imemaddr[31:2];
      if (fill_done)  valid[miss_word[IDX_BITS-1:0]] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (fill_done) begin
      tags[miss_word[IDX_BITS-1:0]] <= miss_word[29:IDX_BITS];
      data[miss_word[IDX_BITS-1:0]] <= bus.iload;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (bus.ihit)  hit_cnt  <= hit_cnt + 32'd1;
      if (start_fill) miss_cnt <= miss_cnt + 32'd1;
    end
  end

  assign bus.hit_count  = hit_cnt;
  assign bus.miss_count = miss_cnt;

endmodule
